// File: rtl/jk_seq_pkg.sv
// Shared types for the JK flag sequencer: op codes, FSM states and op -> {J,K} mapping.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_SET = 2'b01,
        OP_CLR = 2'b10,
        OP_TGL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_INIT_SETUP  = 3'd0,
        ST_INIT_STROBE = 3'd1,
        ST_INIT_HOLD   = 3'd2,
        ST_IDLE        = 3'd3,
        ST_SETUP       = 3'd4,
        ST_STROBE      = 3'd5,
        ST_HOLD        = 3'd6
    } state_e;

    // Returns {J,K} with K active-high; the bank pin is KL = ~K.
    function automatic logic [1:0] op_jk(input op_e op);
        case (op)
            OP_SET:  return 2'b10;
            OP_CLR:  return 2'b01;
            OP_TGL:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/jk_flag_sequencer_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, pointer moves past the winner on advance.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    input  logic [W-1:0] winner_in,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id
);

    logic [W-1:0] ptr;

    always_comb begin
        int  pos;
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        pos    = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                gnt_id   = W'(pos);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(winner_in) == N - 1) ? '0 : winner_in + W'(1);
        end
    end

endmodule

// File: rtl/jk_flag_sequencer.sv
// Arbitrates requesters onto a shared JK flop bank and sequences J/KL plus a setup/strobe/hold CLK pulse.
module jk_flag_sequencer
    import jk_seq_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_FLAGS = 8,
    parameter int IDX_W     = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1
) (
    input  logic                       MasterClock,
    input  logic                       RESET,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [IDX_W*NUM_REQ-1:0]   req_idx,
    output logic [NUM_FLAGS-1:0]       J,
    output logic [NUM_FLAGS-1:0]       KL,
    output logic                       CLK,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [NUM_FLAGS-1:0]       shadow_q
);

    localparam int GID_W = $clog2(NUM_REQ);

    state_e               st, st_nxt;
    logic                 init_go;
    logic [NUM_REQ-1:0]   gnt;
    logic [GID_W-1:0]     win;
    logic                 xfer;
    op_e                  op_q, op_w, op_n;
    logic [IDX_W-1:0]     idx_q, idx_w, idx_n;
    logic                 in_rng;
    logic [NUM_FLAGS-1:0] sel;
    logic [1:0]           jk;
    logic [NUM_FLAGS-1:0] j_n, kl_n;
    logic                 clk_n, busy_n, done_n, err_n;

    rr_arbiter #(.N(NUM_REQ), .W(GID_W)) u_arb (
        .clk       (MasterClock),
        .rst       (RESET),
        .req       (req_valid),
        .advance   (xfer),
        .winner_in (win),
        .gnt       (gnt),
        .gnt_id    (win)
    );

    assign req_ready = (st == ST_IDLE) ? gnt : '0;
    assign xfer      = |req_ready;
    assign op_w      = op_e'(req_op[int'(win)*2 +: 2]);
    assign idx_w     = req_idx[int'(win)*IDX_W +: IDX_W];

    // On the accept edge the decode must see the incoming request, not the stale latch.
    assign op_n   = xfer ? op_w  : op_q;
    assign idx_n  = xfer ? idx_w : idx_q;
    assign in_rng = int'(idx_n) < NUM_FLAGS;
    assign sel    = in_rng ? (NUM_FLAGS'(1) << idx_n) : '0;
    assign jk     = op_jk(op_n);

    always_comb begin
        st_nxt = st;
        if (!init_go) begin
            st_nxt = ST_INIT_SETUP;
        end else begin
            case (st)
                ST_INIT_SETUP:  st_nxt = ST_INIT_STROBE;
                ST_INIT_STROBE: st_nxt = ST_INIT_HOLD;
                ST_INIT_HOLD:   st_nxt = ST_IDLE;
                ST_IDLE:        if (xfer) st_nxt = (op_w == OP_NOP) ? ST_HOLD : ST_SETUP;
                ST_SETUP:       st_nxt = ST_STROBE;
                ST_STROBE:      st_nxt = ST_HOLD;
                ST_HOLD:        st_nxt = ST_IDLE;
                default:        st_nxt = ST_INIT_SETUP;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the phase they name.
    always_comb begin
        j_n    = '0;
        kl_n   = '1;
        clk_n  = 1'b0;
        busy_n = 1'b1;
        done_n = 1'b0;
        err_n  = 1'b0;
        case (st_nxt)
            ST_INIT_SETUP, ST_INIT_HOLD: kl_n = '0;
            ST_INIT_STROBE: begin
                kl_n  = '0;
                clk_n = 1'b1;
            end
            ST_IDLE: busy_n = 1'b0;
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                j_n    = jk[1] ? sel  : '0;
                kl_n   = jk[0] ? ~sel : '1;
                clk_n  = (st_nxt == ST_STROBE);
                done_n = (st_nxt == ST_HOLD);
                err_n  = (st_nxt == ST_HOLD) && !in_rng && (op_n != OP_NOP);
            end
            default: ;
        endcase
    end

    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            st       <= ST_INIT_SETUP;
            init_go  <= 1'b0;
            op_q     <= OP_NOP;
            idx_q    <= '0;
            J        <= '0;
            KL       <= '1;
            CLK      <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            grant_id <= '0;
            shadow_q <= '0;
        end else begin
            init_go <= 1'b1;
            st      <= st_nxt;
            J       <= j_n;
            KL      <= kl_n;
            CLK     <= clk_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
            if (xfer) begin
                op_q     <= op_w;
                idx_q    <= idx_w;
                grant_id <= win;
            end
            if (st == ST_STROBE && in_rng) begin
                case (op_q)
                    OP_SET:  shadow_q <= shadow_q | sel;
                    OP_CLR:  shadow_q <= shadow_q & ~sel;
                    OP_TGL:  shadow_q <= shadow_q ^ sel;
                    default: ;
                endcase
            end
        end
    end

endmodule
